// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StRelease
    } key_state_e;

    // Indexed {row, col}: entry 0 is r0/c0, entry 15 is r3/c3.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the active-low keypad row returns; idles high (no key).
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// Self-timed 4x4 keypad scanner with per-scan debounce and one-cycle key strobe.
// Optional auto-repeat of the strobe while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 10000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam logic [3:0]  DebN = 4'(DEBOUNCE_SCANS);

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      col_q, col_d;
    logic [15:0]     snap_q, snap_d;
    key_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;
    logic            multi_q, multi_d;

    logic [3:0]  row_sync;
    logic [15:0] cur_bits, scan_bits;
    logic [4:0]  hits;
    logic [3:0]  hit_idx;
    logic [3:0]  scan_code;
    logic        last_div, scan_end, is_none, is_single, is_multi;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
    logic [RepW-1:0] rep_q, rep_d;
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_SCANS == 0);
`endif

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_in),
        .q_o   (row_sync)
    );

    assign last_div = (div_q == DivW'(SCAN_DIV - 1));
    assign scan_end = ena && last_div && (col_q == 2'd3);

    // Snapshot at scan end includes the column being sampled on that same edge.
    always_comb begin
        cur_bits = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                cur_bits[r*NUM_COLS+c] = (col_q == 2'(c)) && !row_sync[r];
            end
        end
        scan_bits = snap_q | cur_bits;
        hits      = '0;
        hit_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_bits[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
        is_none   = (hits == 5'd0);
        is_single = (hits == 5'd1);
        is_multi  = (hits > 5'd1);
        scan_code = KEY_MAP[hit_idx];
    end

    always_comb begin
        div_d   = div_q;
        col_d   = col_q;
        snap_d  = snap_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        multi_d = multi_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (!ena) begin
            div_d   = '0;
            col_d   = '0;
            snap_d  = '0;
            state_d = StIdle;
            cnt_d   = '0;
            cand_d  = '0;
            multi_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
        end else begin
            if (last_div) begin
                div_d  = '0;
                col_d  = col_q + 2'd1;
                snap_d = scan_end ? 16'h0000 : scan_bits;
            end else begin
                div_d = div_q + DivW'(1);
            end
            if (scan_end) begin
                multi_d = is_multi;
                unique case (state_q)
                    StIdle: begin
                        if (is_single) begin
                            cand_d = scan_code;
                            cnt_d  = 4'd1;
                            if (DebN == 4'd1) begin
                                code_d  = scan_code;
                                valid_d = 1'b1;
                                state_d = StPressed;
`ifdef KEYPAD_REPEAT_EN
                                rep_d   = '0;
`endif
                            end else begin
                                state_d = StDebounce;
                            end
                        end
                    end
                    StDebounce: begin
                        if (is_single && scan_code == cand_q) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == DebN) begin
                                code_d  = cand_q;
                                valid_d = 1'b1;
                                state_d = StPressed;
`ifdef KEYPAD_REPEAT_EN
                                rep_d   = '0;
`endif
                            end
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    StPressed: begin
                        if (is_none) begin
                            cnt_d   = 4'd1;
                            state_d = (DebN == 4'd1) ? StIdle : StRelease;
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rep_q == RepW'(REPEAT_SCANS - 1)) begin
                            valid_d = 1'b1;
                            rep_d   = '0;
                        end else begin
                            rep_d = rep_q + RepW'(1);
                        end
`endif
                    end
                    StRelease: begin
                        if (is_none) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == DebN) begin
                                state_d = StIdle;
                            end
                        end else begin
                            state_d = StPressed;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
        held_d = ena && (state_d == StPressed || state_d == StRelease);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            col_q   <= '0;
            snap_q  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            div_q   <= div_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            multi_q <= multi_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // Outputs drop immediately with ena; key_code is deliberately retained.
    assign col_out   = ena ? ~(4'b0001 << col_q) : 4'b1111;
    assign key_code  = code_q;
    assign key_valid = valid_q && ena;
    assign key_held  = held_q && ena;
    assign multi_key = multi_q && ena;

endmodule
